// File: rtl/frame_load_ctrl.sv
// frame_load_ctrl
//   Sequences one image load from the byte parser into the frame buffer.
//   Arms/re-arms the parser via parser_reset, validates the parsed image
//   dimensions, and writes each RGB pixel (packed to RGB444) to a linear
//   frame-buffer address. Reports completion, size errors and stalls.
//
// Ports
//   clk                in  1       system clock
//   reset_n            in  1       synchronous reset, active-low
//   start              in  1       1-cycle pulse: (re)arm a frame load
//   height, width      in  16      parsed image dimensions
//   dimension_received in  1       parser header complete (level)
//   one_byte_ready     in  1       parser pixel strobe (1 cycle)
//   data_r/g/b         in  8       parser pixel, valid with one_byte_ready
//   parser_reset       out 1       active-high reset to the parser
//   fb_we              out 1       frame-buffer write enable (1-cycle pulse)
//   fb_addr            out ADDR_W  frame-buffer write address
//   fb_wdata           out 12      {r[7:4], g[7:4], b[7:4]}
//   pixel_count        out ADDR_W  pixels written this frame
//   busy               out 1       loading in progress (WAIT_DIM/CHECK/LOAD)
//   frame_done         out 1       frame fully written (level)
//   err_size           out 1       dimensions rejected (sticky)
//   err_timeout        out 1       pixel stream stalled (sticky)
module frame_load_ctrl #(
  parameter int ADDR_W      = 17,
  parameter int MAX_PIXELS  = 76800,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [15:0]       height,
  input  logic [15:0]       width,
  input  logic              dimension_received,
  input  logic              one_byte_ready,
  input  logic [7:0]        data_r,
  input  logic [7:0]        data_g,
  input  logic [7:0]        data_b,
  output logic              parser_reset,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [11:0]       fb_wdata,
  output logic [ADDR_W-1:0] pixel_count,
  output logic              busy,
  output logic              frame_done,
  output logic              err_size,
  output logic              err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_DIM = 3'd1,
    S_CHECK    = 3'd2,
    S_LOAD     = 3'd3,
    S_DONE     = 3'd4,
    S_ERROR    = 3'd5
  } state_t;

  localparam int                 TIMER_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);
  localparam logic [31:0]        MAX_TOTAL  = 32'(MAX_PIXELS);

  state_t             state_r;
  logic [31:0]        total_r;
  logic [TIMER_W-1:0] timer_r;
  logic               skid_valid_r;
  logic [11:0]        skid_data_r;

  logic [11:0] pixel_packed;
  logic [31:0] count_next;
  logic        unused_low_bits;

  assign pixel_packed    = {data_r[7:4], data_g[7:4], data_b[7:4]};
  assign count_next      = 32'(pixel_count) + 32'd1;
  assign unused_low_bits = ^{data_r[3:0], data_g[3:0], data_b[3:0]};

  // Load sequencer: state, counters, skid entry and all registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r      <= S_IDLE;
      total_r      <= 32'd0;
      timer_r      <= '0;
      skid_valid_r <= 1'b0;
      skid_data_r  <= 12'd0;
      parser_reset <= 1'b1;
      fb_we        <= 1'b0;
      fb_addr      <= '0;
      fb_wdata     <= 12'd0;
      pixel_count  <= '0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      err_size     <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      fb_we <= 1'b0;
      if (start) begin
        // Start always wins, including over a final pixel strobe. The parser
        // is pulsed only when aborting a load that was already under way.
        state_r      <= S_WAIT_DIM;
        parser_reset <= (state_r == S_WAIT_DIM) || (state_r == S_CHECK) ||
                        (state_r == S_LOAD);
        busy         <= 1'b1;
        pixel_count  <= '0;
        timer_r      <= '0;
        skid_valid_r <= 1'b0;
        frame_done   <= 1'b0;
        err_size     <= 1'b0;
        err_timeout  <= 1'b0;
      end else begin
        case (state_r)
          S_IDLE: begin
            parser_reset <= 1'b1;
            busy         <= 1'b0;
          end
          S_WAIT_DIM: begin
            parser_reset <= 1'b0;
            if (dimension_received) begin
              total_r <= 32'(height) * 32'(width);
              state_r <= S_CHECK;
            end
          end
          S_CHECK: begin
            parser_reset <= 1'b0;
            if ((total_r == 32'd0) || (total_r > MAX_TOTAL)) begin
              state_r      <= S_ERROR;
              err_size     <= 1'b1;
              parser_reset <= 1'b1;
              busy         <= 1'b0;
              skid_valid_r <= 1'b0;
            end else begin
              // A pixel arriving while dimensions are checked is parked here.
              state_r      <= S_LOAD;
              timer_r      <= '0;
              skid_valid_r <= one_byte_ready;
              skid_data_r  <= pixel_packed;
            end
          end
          S_LOAD: begin
            parser_reset <= 1'b0;
            if (skid_valid_r || one_byte_ready) begin
              // The skid pixel is older, so it goes first; a simultaneous new
              // strobe takes its place in the skid for the next cycle.
              fb_we        <= 1'b1;
              fb_addr      <= pixel_count;
              fb_wdata     <= skid_valid_r ? skid_data_r : pixel_packed;
              pixel_count  <= pixel_count + ADDR_W'(1);
              skid_valid_r <= skid_valid_r && one_byte_ready;
              skid_data_r  <= pixel_packed;
              timer_r      <= one_byte_ready ? '0 : timer_r + TIMER_W'(1);
              if (count_next == total_r) begin
                state_r      <= S_DONE;
                busy         <= 1'b0;
                parser_reset <= 1'b1;
                skid_valid_r <= 1'b0;
              end
            end else if (timer_r == TIMER_LAST) begin
              state_r      <= S_ERROR;
              err_timeout  <= 1'b1;
              busy         <= 1'b0;
              parser_reset <= 1'b1;
            end else begin
              timer_r <= timer_r + TIMER_W'(1);
            end
          end
          S_DONE: begin
            frame_done   <= 1'b1;
            parser_reset <= 1'b1;
            busy         <= 1'b0;
          end
          S_ERROR: begin
            parser_reset <= 1'b1;
            busy         <= 1'b0;
          end
          default: begin
            state_r      <= S_IDLE;
            parser_reset <= 1'b1;
            busy         <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_load_ctrl.sv
// Testbench for frame_load_ctrl: directed frames, expected frame-buffer
// writes queued by the stimulus and popped by a monitor thread.
module tb_frame_load_ctrl;

  localparam int ADDR_W = 17;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [15:0]       height = 16'd0;
  logic [15:0]       width = 16'd0;
  logic              dimension_received = 1'b0;
  logic              one_byte_ready = 1'b0;
  logic [7:0]        data_r = 8'd0;
  logic [7:0]        data_g = 8'd0;
  logic [7:0]        data_b = 8'd0;
  logic              parser_reset;
  logic              fb_we;
  logic [ADDR_W-1:0] fb_addr;
  logic [11:0]       fb_wdata;
  logic [ADDR_W-1:0] pixel_count;
  logic              busy;
  logic              frame_done;
  logic              err_size;
  logic              err_timeout;

  int vectors = 0;
  int miscompares = 0;
  logic [28:0] exp_q[$];   // {addr[16:0], wdata[11:0]}

  frame_load_ctrl #(
    .ADDR_W(ADDR_W), .MAX_PIXELS(76800), .TIMEOUT_CYC(100)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .height(height), .width(width),
    .dimension_received(dimension_received), .one_byte_ready(one_byte_ready),
    .data_r(data_r), .data_g(data_g), .data_b(data_b),
    .parser_reset(parser_reset), .fb_we(fb_we), .fb_addr(fb_addr),
    .fb_wdata(fb_wdata), .pixel_count(pixel_count), .busy(busy),
    .frame_done(frame_done), .err_size(err_size), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic expect_wr(input logic [16:0] addr, input logic [11:0] data);
    exp_q.push_back({addr, data});
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_header(input logic [15:0] h, input logic [15:0] w);
    height = h;
    width = w;
    dimension_received = 1'b1;
    tick();
    dimension_received = 1'b0;
  endtask

  task automatic send_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    data_r = r;
    data_g = g;
    data_b = b;
    one_byte_ready = 1'b1;
    tick();
    one_byte_ready = 1'b0;
  endtask

  // Pops one expected write for every fb_we pulse seen.
  task automatic monitor();
    logic [28:0] e;
    forever begin
      @(negedge clk);
      if (fb_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                   fb_addr, fb_wdata);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(fb_addr), 32'(e[28:12]));
          check("wr_data", 32'(fb_wdata), 32'(e[11:0]));
        end
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    // Reset state
    tick();
    tick();
    check("rst_parser_reset", 32'(parser_reset), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fb_we", 32'(fb_we), 32'd0);
    check("rst_pixel_count", 32'(pixel_count), 32'd0);
    check("rst_flags", 32'({frame_done, err_size, err_timeout}), 32'd0);
    reset_n = 1'b1;
    tick();
    check("idle_parser_reset", 32'(parser_reset), 32'd1);

    // 1) 2x3 frame
    do_start();
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_parser_armed", 32'(parser_reset), 32'd0);
    send_header(16'd2, 16'd3);
    tick();
    expect_wr(17'd0, 12'hACE);
    expect_wr(17'd1, 12'h135);
    expect_wr(17'd2, 12'hF08);
    expect_wr(17'd3, 12'h789);
    expect_wr(17'd4, 12'h024);
    expect_wr(17'd5, 12'hF0C);
    send_pixel(8'hAB, 8'hCD, 8'hEF);
    send_pixel(8'h12, 8'h34, 8'h56);
    tick();
    send_pixel(8'hFF, 8'h00, 8'h80);
    send_pixel(8'h7F, 8'h80, 8'h9A);
    tick();
    tick();
    send_pixel(8'h01, 8'h23, 8'h45);
    send_pixel(8'hF0, 8'h0F, 8'hC3);
    check("t1_done_not_yet", 32'(frame_done), 32'd0);
    check("t1_busy_low", 32'(busy), 32'd0);
    tick();
    check("t1_frame_done", 32'(frame_done), 32'd1);
    check("t1_pixel_count", 32'(pixel_count), 32'd6);
    check("t1_parser_reset", 32'(parser_reset), 32'd1);
    send_pixel(8'h11, 8'h22, 8'h33);  // ignored in DONE
    check("t1_queue_empty", 32'(exp_q.size()), 32'd0);

    // 2) 300x300 too large
    do_start();
    check("t2_done_cleared", 32'(frame_done), 32'd0);
    send_header(16'd300, 16'd300);
    tick();
    check("t2_err_size", 32'(err_size), 32'd1);
    check("t2_busy", 32'(busy), 32'd0);
    check("t2_parser_reset", 32'(parser_reset), 32'd1);
    tick();
    tick();
    check("t2_err_sticky", 32'(err_size), 32'd1);

    // 3) zero size, then a 1x1 frame
    do_start();
    check("t3_err_cleared_a", 32'(err_size), 32'd0);
    send_header(16'd0, 16'd5);
    tick();
    check("t3_err_size_zero", 32'(err_size), 32'd1);
    do_start();
    check("t3_err_cleared_b", 32'(err_size), 32'd0);
    send_header(16'd1, 16'd1);
    tick();
    expect_wr(17'd0, 12'h135);
    send_pixel(8'h12, 8'h34, 8'h56);
    tick();
    check("t3_frame_done", 32'(frame_done), 32'd1);
    check("t3_err_size", 32'(err_size), 32'd0);
    check("t3_queue_empty", 32'(exp_q.size()), 32'd0);

    // 4) stall timeout on a 2x2 frame
    do_start();
    send_header(16'd2, 16'd2);
    tick();
    expect_wr(17'd0, 12'h123);
    expect_wr(17'd1, 12'h456);
    send_pixel(8'h10, 8'h20, 8'h30);
    send_pixel(8'h40, 8'h50, 8'h60);
    for (int i = 0; i < 99; i++) tick();
    check("t4_no_timeout_yet", 32'(err_timeout), 32'd0);
    tick();
    check("t4_err_timeout", 32'(err_timeout), 32'd1);
    check("t4_pixel_count", 32'(pixel_count), 32'd2);
    check("t4_busy", 32'(busy), 32'd0);
    send_pixel(8'h70, 8'h80, 8'h90);  // must not be written
    tick();
    check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

    // 5) restart mid-load, strobe in the restart cycle dropped
    do_start();
    check("t5_err_cleared", 32'(err_timeout), 32'd0);
    send_header(16'd4, 16'd4);
    tick();
    expect_wr(17'd0, 12'hAAA);
    expect_wr(17'd1, 12'hBBB);
    expect_wr(17'd2, 12'hCCC);
    send_pixel(8'hA0, 8'hA0, 8'hA0);
    send_pixel(8'hB0, 8'hB0, 8'hB0);
    send_pixel(8'hC0, 8'hC0, 8'hC0);
    check("t5_count_before", 32'(pixel_count), 32'd3);
    data_r = 8'hDD;
    data_g = 8'hDD;
    data_b = 8'hDD;
    one_byte_ready = 1'b1;
    do_start();
    one_byte_ready = 1'b0;
    check("t5_parser_pulse", 32'(parser_reset), 32'd1);
    check("t5_count_cleared", 32'(pixel_count), 32'd0);
    check("t5_busy", 32'(busy), 32'd1);
    tick();
    check("t5_parser_pulse_end", 32'(parser_reset), 32'd0);
    send_header(16'd1, 16'd2);
    tick();
    expect_wr(17'd0, 12'h111);
    expect_wr(17'd1, 12'h222);
    send_pixel(8'h10, 8'h10, 8'h10);
    send_pixel(8'h20, 8'h20, 8'h20);
    tick();
    check("t5_frame_done", 32'(frame_done), 32'd1);
    check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

    // 6) strobes in CHECK and first LOAD cycle, then reset mid-load
    do_start();
    send_header(16'd2, 16'd2);
    expect_wr(17'd0, 12'h5A3);
    expect_wr(17'd1, 12'h69C);
    send_pixel(8'h55, 8'hAA, 8'h33);  // arrives in CHECK
    check("t6_no_write_in_check", 32'(fb_we), 32'd0);
    send_pixel(8'h66, 8'h99, 8'hCC);  // first LOAD cycle: skid pixel written
    tick();                            // second pixel from skid
    check("t6_pixel_count", 32'(pixel_count), 32'd2);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("t6_rst_parser_reset", 32'(parser_reset), 32'd1);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_pixel_count", 32'(pixel_count), 32'd0);
    check("t6_rst_addr_data", 32'({fb_we, fb_addr, fb_wdata}), 32'd0);
    check("t6_rst_flags", 32'({frame_done, err_size, err_timeout}), 32'd0);
    tick();
    check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
